fxp32s_stream_accum: RTL and testbench

- Streaming accumulator that sits directly downstream of the sign-magnitude add/sub stage in the fxp32s datapath.
- Consumes a framed stream of fxp32s words. Format: bit 31 = sign, bits 30:0 = magnitude.
- Each word carries a per-sample add/subtract flag. The block sums the frame into a sign-magnitude accumulator with saturation.
- At frame end it presents the result, the sample count and a sticky overflow flag on a valid/ready output.

---
 rtl/fxp32s_stream_accum.sv | 140 ++++++++++++++
 tb/tb_fxp32s_stream_accum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fxp32s_stream_accum.sv
// Framed sign-magnitude stream accumulator with magnitude saturation.
// Sums a frame of fxp32s samples and presents result, sample count and sticky overflow.
module fxp32s_stream_accum #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MW = WIDTH - 1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             signA, signB, resSign, satNow, accept;
  logic [MW-1:0]    magA, magB, resMag;
  logic [MW:0]      magSum;
  logic [CNT_W-1:0] cntInc;
  logic [WIDTH-1:0] accRes;

  assign signA  = acc_q[MW];
  assign magA   = acc_q[MW-1:0];
  assign signB  = in_data[MW] ^ in_sub;
  assign magB   = in_data[MW-1:0];
  assign magSum = {1'b0, magA} + {1'b0, magB};
  assign cntInc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign accept = in_valid & in_ready_q & (state_q == ACC);

  // Sign-magnitude add with saturation; a zero magnitude is always stored as +0.
  always_comb begin
    resSign = signA;
    resMag  = '0;
    satNow  = 1'b0;
    if (signA == signB) begin
      if (magSum[MW]) begin
        resMag = '1;
        satNow = 1'b1;
      end else begin
        resMag = magSum[MW-1:0];
      end
    end else if (magA >= magB) begin
      resMag = magA - magB;
    end else begin
      resSign = signB;
      resMag  = magB - magA;
    end
    if (resMag == '0) resSign = 1'b0;
    accRes = {resSign, resMag};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = accRes;
          cnt_d = cntInc;
          ovf_d = ovf_q | satNow;
          if (in_last) begin
            state_d     = HOLD;
            out_data_d  = accRes;
            out_count_d = cntInc;
            out_ovf_d   = ovf_q | satNow;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ACC;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
    // Registered ready keeps in_ready low through reset and the handoff cycle.
    in_ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fxp32s_stream_accum.sv
// Directed bench for fxp32s_stream_accum with a queue of expected frame results.
// The counter is narrowed to 2 bits so saturation is reachable with a short frame.
module tb_fxp32s_stream_accum;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  fxp32s_stream_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c, input logic o);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.ovf   = o;
    expQ.push_back(e);
  endtask

  // Present one sample and hold it until accepted; a frame result must follow one edge later.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic s, input logic l);
    bit accepted;
    accepted = 1'b0;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("sample_accepted", 32'(accepted), 32'd1);
    if (l) check("last_to_valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    check({tag, "_scoreboard_nonempty"}, 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      check({tag, "_data"}, out_data, e.data);
      check({tag, "_count"}, 32'(out_count), 32'(e.count));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_restored"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a frame drops the partial sum.
    applyStimulus(32'h0000_0040, 1'b0, 1'b0);
    applyStimulus(32'h0000_0011, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_release_ready", 32'(in_ready), 32'd1);

    applyStimulus(32'h0000_0005, 1'b0, 1'b0);
    applyStimulus(32'h8000_0003, 1'b0, 1'b0);
    applyStimulus(32'h0000_0002, 1'b1, 1'b1);
    pushExpected(32'h0000_0000, 2'd3, 1'b0);
    checkOutput("mixed_sign");

    applyStimulus(32'h0000_0004, 1'b0, 1'b0);
    applyStimulus(32'h0000_000A, 1'b1, 1'b0);
    applyStimulus(32'h8000_0001, 1'b1, 1'b1);
    pushExpected(32'h8000_0005, 2'd3, 1'b0);
    checkOutput("crossover");

    applyStimulus(32'h7FFF_FFF0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0020, 1'b0, 1'b0);
    applyStimulus(32'h8000_0010, 1'b0, 1'b1);
    pushExpected(32'h7FFF_FFEF, 2'd3, 1'b1);
    checkOutput("saturation");

    // Backpressure frame also proves the overflow flag was cleared.
    applyStimulus(32'h0000_0003, 1'b0, 1'b0);
    applyStimulus(32'h0000_0004, 1'b0, 1'b1);
    pushExpected(32'h0000_0007, 2'd2, 1'b0);
    in_data  = 32'h0000_0100;
    in_sub   = 1'b0;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h0000_0007);
      check("bp_out_count", 32'(out_count), 32'd2);
    end
    checkOutput("backpressure");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    applyStimulus(32'h0000_0001, 1'b0, 1'b1);
    pushExpected(32'h0000_0101, 2'd2, 1'b0);
    checkOutput("after_handoff");

    for (int i = 0; i < 5; i++) applyStimulus(32'h0000_0001, 1'b0, (i == 4));
    pushExpected(32'h0000_0005, 2'd3, 1'b0);
    checkOutput("count_saturate");

    applyStimulus(32'h8000_0000, 1'b1, 1'b1);
    pushExpected(32'h0000_0000, 2'd1, 1'b0);
    checkOutput("single_neg_zero");

    // Reset while a result is pending discards it.
    applyStimulus(32'h0000_0055, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("holdreset_out_valid", 32'(out_valid), 32'd0);
    check("holdreset_out_data", out_data, 32'd0);
    check("holdreset_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0009, 1'b0, 1'b1);
    pushExpected(32'h0000_0009, 2'd1, 1'b0);
    checkOutput("after_hold_reset");

    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
